hilo_ctrl: RTL and testbench

- Sequencer and HI/LO register stage directly downstream of the multiplier and divider units.
- Accepts MULT/DIV/MTHI/MTLO requests from the control unit and latches operands.
- Launches the selected arithmetic unit, waits for its completion, and captures its hi/lo results into the architectural HI/LO registers.
- Drives busy (pipeline stall) and the divide-by-zero exception.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_ctrl_if.sv | 26 ++
 rtl/hilo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hilo_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO sequencer: op_sel encoding, FSM states
// and the default datapath width.
package hilo_pkg;

  localparam int HILO_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_MTHI = 2'd2,
    OP_MTLO = 2'd3
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_MUL_WAIT,
    ST_DIV_WAIT
  } state_e;

endpackage

// File: rtl/hilo_ctrl_if.sv
// Bus between hilo_ctrl and the external multiplier/divider units: launch pulses,
// latched operands and the returning results.
interface hilo_ctrl_if #(
  parameter int DATA_W = hilo_pkg::HILO_DATA_W
);
  logic              mul_start;
  logic              div_start;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;
  logic              div_done;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;

  modport master (
    output mul_start, div_start, unit_a, unit_b,
    input  mul_done, mul_hi, mul_lo, div_done, div_hi, div_lo
  );

  modport slave (
    input  mul_start, div_start, unit_a, unit_b,
    output mul_done, mul_hi, mul_lo, div_done, div_hi, div_lo
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register stage and MULT/DIV/MTHI/MTLO sequencer.
// Optional macro HILO_BYPASS_EN forwards the captured value to hi_out/lo_out one cycle early.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W         = HILO_DATA_W,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic [1:0]        op_sel,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  hilo_ctrl_if.master       unit_bus,
  output logic              busy,
  output logic              op_done,
  output logic              div0,
  output logic              op_err,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_reg, state_next;
  op_sel_e           op_reg, op_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic [DATA_W-1:0] lo_reg, lo_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              op_done_reg, op_done_next;
  logic              div0_reg, div0_next;
  logic              op_err_reg, op_err_next;
  logic              mul_start_w, div_start_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_MULT;
      hi_reg      <= '0;
      lo_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      op_done_reg <= 1'b0;
      div0_reg    <= 1'b0;
      op_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      cnt_reg     <= cnt_next;
      op_done_reg <= op_done_next;
      div0_reg    <= div0_next;
      op_err_reg  <= op_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    cnt_next     = cnt_reg;
    op_done_next = 1'b0;
    div0_next    = 1'b0;
    op_err_next  = 1'b0;
    mul_start_w  = 1'b0;
    div_start_w  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (op_start) begin
          case (op_sel_e'(op_sel))
            OP_MTHI: begin
              hi_next      = rs_val;
              op_done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next      = rs_val;
              op_done_next = 1'b1;
            end
            OP_DIV: begin
              // A zero divisor never reaches the divider; raise the exception instead.
              if (rt_val == '0) begin
                div0_next = 1'b1;
              end else begin
                a_next     = rs_val;
                b_next     = rt_val;
                op_next    = OP_DIV;
                state_next = ST_LAUNCH;
              end
            end
            default: begin
              a_next     = rs_val;
              b_next     = rt_val;
              op_next    = OP_MULT;
              state_next = ST_LAUNCH;
            end
          endcase
        end
      end

      ST_LAUNCH: begin
        cnt_next = '0;
        if (op_reg == OP_DIV) begin
          div_start_w = 1'b1;
          state_next  = ST_DIV_WAIT;
        end else begin
          mul_start_w = 1'b1;
          state_next  = ST_MUL_WAIT;
        end
      end

      ST_MUL_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // Completion takes priority over a coincident timeout.
        if (unit_bus.mul_done) begin
          hi_next      = unit_bus.mul_hi;
          lo_next      = unit_bus.mul_lo;
          op_done_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          op_err_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      ST_DIV_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (unit_bus.div_done) begin
          hi_next      = unit_bus.div_hi;
          lo_next      = unit_bus.div_lo;
          op_done_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          op_err_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign unit_bus.mul_start = mul_start_w;
  assign unit_bus.div_start = div_start_w;
  assign unit_bus.unit_a    = a_reg;
  assign unit_bus.unit_b    = b_reg;

  assign busy    = (state_reg != ST_IDLE);
  assign op_done = op_done_reg;
  assign div0    = div0_reg;
  assign op_err  = op_err_reg;

`ifdef HILO_BYPASS_EN
  // The next-state value already carries the captured result in the capture cycle.
  assign hi_out = hi_next;
  assign lo_out = lo_next;
`else
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl; the bench plays the multiplier and
// divider units by hand.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [1:0]  op_sel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy, op_done, div0, op_err;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  int busy_cnt, ms_cnt, ds_cnt, done_cnt, div0_cnt, err_cnt;

  hilo_ctrl_if #(.DATA_W(32)) unit_bus ();

  hilo_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(40)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_start (op_start),
    .op_sel   (op_sel),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .unit_bus (unit_bus.master),
    .busy     (busy),
    .op_done  (op_done),
    .div0     (div0),
    .op_err   (op_err),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0; ms_cnt = 0; ds_cnt = 0; done_cnt = 0; div0_cnt = 0; err_cnt = 0;
  endtask

  // Advance one cycle and sample outputs just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy)               busy_cnt++;
    if (unit_bus.mul_start) ms_cnt++;
    if (unit_bus.div_start) ds_cnt++;
    if (op_done)            done_cnt++;
    if (div0)               div0_cnt++;
    if (op_err)             err_cnt++;
  endtask

  task automatic request(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    op_start = 1'b1;
    op_sel   = sel;
    rs_val   = a;
    rt_val   = b;
  endtask

  initial begin
    int waited;
    reset = 1'b1; op_start = 1'b0; op_sel = 2'd0; rs_val = '0; rt_val = '0;
    unit_bus.mul_done = 1'b0; unit_bus.mul_hi = '0; unit_bus.mul_lo = '0;
    unit_bus.div_done = 1'b0; unit_bus.div_hi = '0; unit_bus.div_lo = '0;
    clear_counts();

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_op_done", op_done, 0);
    check("rst_unit_a", unit_bus.unit_a, 0);
    $display("txn reset done");

    // MTHI
    clear_counts();
    request(2'd2, 32'hDEADBEEF, 32'h0);
    tick();
    op_start = 1'b0;
    check("mthi_hi", hi_out, 32'hDEADBEEF);
    check("mthi_lo", lo_out, 0);
    check("mthi_done", op_done, 1);
    tick();
    check("mthi_done_pulse", op_done, 0);
    check("mthi_busy_cnt", busy_cnt, 0);
    $display("txn MTHI hi=%h", hi_out);

    // MULT with the unit answering 34 cycles after mul_start
    clear_counts();
    request(2'd0, 32'hFFFFFFFE, 32'd3);
    tick();
    op_start = 1'b0;
    check("mul_start_seen", unit_bus.mul_start, 1);
    check("mul_unit_a", unit_bus.unit_a, 32'hFFFFFFFE);
    check("mul_unit_b", unit_bus.unit_b, 32'd3);
    repeat (34) tick();
    check("mul_hi_before", hi_out, 32'hDEADBEEF);
    unit_bus.mul_done = 1'b1; unit_bus.mul_hi = 32'hFFFFFFFF; unit_bus.mul_lo = 32'hFFFFFFFA;
    tick();
    unit_bus.mul_done = 1'b0;
    check("mul_done", op_done, 1);
    check("mul_hi", hi_out, 32'hFFFFFFFF);
    check("mul_lo", lo_out, 32'hFFFFFFFA);
    tick();
    check("mul_busy_cnt", busy_cnt, 35);
    check("mul_start_cnt", ms_cnt, 1);
    check("mul_div_start_cnt", ds_cnt, 0);
    check("mul_done_cnt", done_cnt, 1);
    check("mul_unit_a_hold", unit_bus.unit_a, 32'hFFFFFFFE);
    $display("txn MULT hi=%h lo=%h busy_cycles=%0d", hi_out, lo_out, busy_cnt);

    // DIV by zero
    clear_counts();
    request(2'd1, 32'd100, 32'd0);
    tick();
    op_start = 1'b0;
    check("div0_pulse", div0, 1);
    tick();
    check("div0_cnt", div0_cnt, 1);
    check("div0_no_start", ds_cnt, 0);
    check("div0_busy_cnt", busy_cnt, 0);
    check("div0_done_cnt", done_cnt, 0);
    check("div0_hi", hi_out, 32'hFFFFFFFF);
    check("div0_lo", lo_out, 32'hFFFFFFFA);
    $display("txn DIV0 div0_pulses=%0d", div0_cnt);

    // DIV with no done: timeout after 40 wait cycles
    clear_counts();
    request(2'd1, 32'd100, 32'd7);
    tick();
    op_start = 1'b0;
    check("to_div_start", unit_bus.div_start, 1);
    waited = 0;
    while (!op_err && waited < 100) begin
      tick();
      waited++;
    end
    check("to_wait_cycles", waited, 41);
    check("to_busy_after", busy, 0);
    check("to_busy_cnt", busy_cnt, 41);
    check("to_err_cnt", err_cnt, 1);
    check("to_hi", hi_out, 32'hFFFFFFFF);
    check("to_lo", lo_out, 32'hFFFFFFFA);
    check("to_unit_b", unit_bus.unit_b, 32'd7);
    tick();
    check("to_err_pulse", op_err, 0);
    $display("txn DIV timeout after %0d cycles", waited);

    // Reset in the middle of a MULT; the late done is ignored
    clear_counts();
    request(2'd0, 32'd5, 32'd6);
    tick();
    op_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_busy", busy, 0);
    check("rmid_hi", hi_out, 0);
    check("rmid_lo", lo_out, 0);
    check("rmid_unit_a", unit_bus.unit_a, 0);
    repeat (22) tick();
    unit_bus.mul_done = 1'b1; unit_bus.mul_hi = 32'h1111; unit_bus.mul_lo = 32'h2222;
    tick();
    unit_bus.mul_done = 1'b0;
    tick();
    check("rmid_late_hi", hi_out, 0);
    check("rmid_late_lo", lo_out, 0);
    check("rmid_done_cnt", done_cnt, 0);
    request(2'd0, 32'd9, 32'd4);
    tick();
    op_start = 1'b0;
    check("rmid_new_busy", busy, 1);
    check("rmid_new_start", unit_bus.mul_start, 1);
    tick();
    unit_bus.mul_done = 1'b1; unit_bus.mul_hi = 32'd0; unit_bus.mul_lo = 32'd36;
    tick();
    unit_bus.mul_done = 1'b0;
    check("rmid_new_lo", lo_out, 32'd36);
    $display("txn reset-mid-MULT lo=%h", lo_out);

    // MTLO while DIV is busy, stray mul_done in wait and in IDLE
    clear_counts();
    request(2'd1, 32'd50, 32'd7);
    tick();
    request(2'd3, 32'h0000ABCD, 32'd0);
    repeat (3) tick();
    unit_bus.mul_done = 1'b1; unit_bus.mul_hi = 32'h5555; unit_bus.mul_lo = 32'h5555;
    tick();
    unit_bus.mul_done = 1'b0;
    check("mtlo_still_busy", busy, 1);
    unit_bus.div_done = 1'b1; unit_bus.div_hi = 32'd1; unit_bus.div_lo = 32'd7;
    tick();
    unit_bus.div_done = 1'b0;
    op_start = 1'b0;
    check("mtlo_div_done", op_done, 1);
    check("mtlo_div_hi", hi_out, 32'd1);
    check("mtlo_div_lo", lo_out, 32'd7);
    tick();
    unit_bus.mul_done = 1'b1; unit_bus.mul_hi = 32'hEEEE; unit_bus.mul_lo = 32'hFFFF;
    tick();
    unit_bus.mul_done = 1'b0;
    tick();
    check("idle_done_hi", hi_out, 32'd1);
    check("idle_done_lo", lo_out, 32'd7);
    check("idle_done_cnt", done_cnt, 1);
    check("idle_busy", busy, 0);
    $display("txn DIV with ignored MTLO hi=%h lo=%h", hi_out, lo_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
